jaxis_frame_gate: RTL
=====================

Name: jaxis_frame_gate

Overview:
- Capture controller between the camera AXI4-Stream video source and the JPEG encoder's AXI-Stream video slave.
- Software arms a single-frame or continuous capture. The block discards traffic until a start-of-frame (SOF), then forwards exactly one frame per capture.
- While forwarding, it checks line length and line count against the configured geometry and regenerates end-of-line (EOL) so the encoder always sees x_size_m1+1 pixels on a full-length line.
- Reports frame_start / frame_done pulses, sticky error flags and a frame counter.

Parameters:
- SENSOR_X_SIZE, 720, maximum line width in pixels; sets XW = $clog2(SENSOR_X_SIZE).
- SENSOR_Y_SIZE, 720, maximum frame height in lines; sets YW = $clog2(SENSOR_Y_SIZE).
- FCW, 16, width of frame_count.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- s_axis_video_tdata  in  24  pixel {B,G,R}.
- s_axis_video_tvalid  in  1  source beat valid.
- s_axis_video_tready  out  1  source beat accepted.
- s_axis_video_tuser  in  1  SOF.
- s_axis_video_tlast  in  1  EOL.
- m_axis_video_tdata  out  24  forwarded pixel, equal to s_axis_video_tdata (combinational).
- m_axis_video_tvalid  out  1  beat valid toward encoder.
- m_axis_video_tready  in  1  encoder ready.
- m_axis_video_tuser  out  1  SOF toward encoder.
- m_axis_video_tlast  out  1  regenerated EOL.
- x_size_m1  in  XW  line width minus 1; sampled at the SOF handshake.
- y_size_m1  in  YW  frame height minus 1; sampled at the SOF handshake.
- capture_start  in  1  one-cycle pulse that arms a capture.
- capture_continuous  in  1  level; re-arm automatically after each frame.
- capture_abort  in  1  one-cycle pulse that cancels the capture.
- busy  out  1  state != IDLE.
- frame_start  out  1  one-cycle pulse on the forwarded SOF handshake.
- frame_done  out  1  one-cycle pulse when a frame terminates (normally or on error).
- err_early_eol  out  1  sticky: EOL seen before x == x_size_m1.
- err_late_eol  out  1  sticky: no EOL at x == x_size_m1.
- err_sof_midframe  out  1  sticky: SOF arrived while in PASS.
- err_abort  out  1  sticky: abort taken in PASS or DISCARD.
- frame_count  out  FCW  frames completed by frame_done; wraps modulo 2^FCW.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, except s_axis_video_tready = 1.
  - Counters 0, error flags 0, latched sizes 0.
- Handshake rule: a source beat is consumed when s_tvalid & s_tready. A beat is forwarded only when m_tvalid & m_tready. The block adds no latency and has no storage.
- State IDLE:
  - s_tready = 1 (drain); m_tvalid = 0.
  - capture_start -> WAIT_SOF. This also clears all sticky errors.
- State WAIT_SOF:
  - A beat with tuser = 0 is dropped (s_tready = 1, m_tvalid = 0).
  - A beat with tuser = 1 drives m_tvalid = s_tvalid and s_tready = m_tready.
  - On that handshake: latch both sizes, x <= 1, y <= 0, pulse frame_start, go to PASS.
  - If x_size_m1 == 0, the SOF beat itself carries m_tlast and obeys the PASS rules for the end of the line.
- State PASS:
  - m_tvalid = s_tvalid & ~s_tuser; s_tready = m_tready & ~s_tuser; m_tuser = 0.
  - m_tlast = s_tlast | (x == x_size_m1).
  - Each handshake does x <= x+1.
  - On a handshake with m_tlast: x <= 0 and y <= y+1.
    - If s_tlast and x != x_size_m1, set err_early_eol.
    - If x == x_size_m1 and !s_tlast, set err_late_eol and go to DISCARD.
    - If y == y_size_m1, finish the frame (see below).
  - Sizes are frozen while in PASS; changes to x_size_m1 / y_size_m1 have no effect until the next SOF.
- SOF mid-frame: when tuser = 1 in PASS, the beat is not consumed.
  - Next cycle: set err_sof_midframe, pulse frame_done, go to WAIT_SOF.
  - WAIT_SOF then accepts that same beat, so no data is lost.
- State DISCARD:
  - s_tready = 1, m_tvalid = 0.
  - Drop beats up to and including the one with s_tlast, then return to PASS. If the dropped line was the last line, finish the frame instead.
  - A tuser beat in DISCARD is handled as in PASS (SOF mid-frame).
- Frame finish:
  - Pulse frame_done and increment frame_count.
  - Next state is WAIT_SOF if capture_continuous, or if capture_start arrived during the frame; otherwise IDLE.
- capture_start while busy: recorded as pending and consumed at frame finish. It does not clear errors.
- capture_abort in any state: go to IDLE next cycle.
  - In PASS or DISCARD, also set err_abort.
  - No frame_done pulse and no frame_count increment.
  - The pending start is cleared.
  - Abort has priority over a simultaneous capture_start or frame finish.
- Reset mid-frame: immediate return to reset values. The downstream partial frame is not terminated.

Test Plan:
1. x_size_m1=3, y_size_m1=1, single capture, 2×4 frame with tlast on beat 4 and beat 8, m_tready=1 -> 8 beats forwarded; frame_start at beat 1; frame_done one cycle after beat 8; frame_count=1; no errors; back to IDLE.
2. Source sends 5 beats of garbage (tuser=0) before the SOF -> all 5 dropped with s_tready=1, m_tvalid=0; frame then forwarded intact.
3. Line 0 has 6 beats with tlast on beat 6 (x_size_m1=3) -> m_tlast on beat 4; beats 5-6 dropped; err_late_eol=1; line 1 forwarded normally; frame_done pulses.
4. Line 0 has tlast on beat 2 -> err_early_eol=1; 2-beat line forwarded; y advances.
5. SOF injected during line 1 with capture_continuous=1 -> err_sof_midframe=1 and frame_done pulse; the SOF beat is forwarded as the next frame's first beat with frame_start.
6. m_tready toggled 1010..., capture_abort mid-line -> no beat lost or duplicated before the abort; IDLE afterwards; err_abort=1; frame_count unchanged.

Source files
------------

// File: rtl/jaxis_frame_gate.sv
// Capture gate between the camera video stream and the JPEG encoder: forwards exactly one
// frame per capture, enforces the programmed geometry and regenerates end-of-line.
module jaxis_frame_gate #(
  parameter int SENSOR_X_SIZE = 720,
  parameter int SENSOR_Y_SIZE = 720,
  parameter int FCW           = 16,
  localparam int XW = $clog2(SENSOR_X_SIZE),
  localparam int YW = $clog2(SENSOR_Y_SIZE)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [23:0]    s_axis_video_tdata,
  input  logic           s_axis_video_tvalid,
  output logic           s_axis_video_tready,
  input  logic           s_axis_video_tuser,
  input  logic           s_axis_video_tlast,
  output logic [23:0]    m_axis_video_tdata,
  output logic           m_axis_video_tvalid,
  input  logic           m_axis_video_tready,
  output logic           m_axis_video_tuser,
  output logic           m_axis_video_tlast,
  input  logic [XW-1:0]  x_size_m1,
  input  logic [YW-1:0]  y_size_m1,
  input  logic           capture_start,
  input  logic           capture_continuous,
  input  logic           capture_abort,
  output logic           busy,
  output logic           frame_start,
  output logic           frame_done,
  output logic           err_early_eol,
  output logic           err_late_eol,
  output logic           err_sof_midframe,
  output logic           err_abort,
  output logic [FCW-1:0] frame_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_DISC = 2'd3;

  logic [1:0]     r_state;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic [XW-1:0]  r_xsz;
  logic [YW-1:0]  r_ysz;
  logic           r_pending;
  logic           r_disc_last;
  logic           r_frame_done;
  logic [FCW-1:0] r_frame_count;
  logic           r_err_early;
  logic           r_err_late;
  logic           r_err_sof;
  logic           r_err_abort;

  logic           w_hs;
  logic           w_eol;
  logic           w_early;
  logic           w_late;
  logic           w_last_line;
  logic           w_midsof;
  logic           w_disc_end;
  logic           w_finish;
  logic           w_rearm;
  logic [XW-1:0]  w_cur_x;
  logic [XW-1:0]  w_cur_xsz;
  logic [YW-1:0]  w_cur_y;
  logic [YW-1:0]  w_cur_ysz;

  always_comb begin
    s_axis_video_tready = 1'b1;
    m_axis_video_tvalid = 1'b0;
    m_axis_video_tuser  = 1'b0;
    m_axis_video_tlast  = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (s_axis_video_tuser) begin
          m_axis_video_tvalid = s_axis_video_tvalid;
          s_axis_video_tready = m_axis_video_tready;
          m_axis_video_tuser  = 1'b1;
          m_axis_video_tlast  = s_axis_video_tlast | (x_size_m1 == '0);
        end
      end
      S_PASS: begin
        m_axis_video_tvalid = s_axis_video_tvalid & ~s_axis_video_tuser;
        s_axis_video_tready = m_axis_video_tready & ~s_axis_video_tuser;
        m_axis_video_tlast  = s_axis_video_tlast | (r_x == r_xsz);
      end
      S_DISC: s_axis_video_tready = ~s_axis_video_tuser;
      default: ;
    endcase
  end

  // The SOF beat is evaluated as pixel 0 of line 0 against the live size inputs.
  assign w_cur_x     = (r_state == S_WAIT) ? '0 : r_x;
  assign w_cur_y     = (r_state == S_WAIT) ? '0 : r_y;
  assign w_cur_xsz   = (r_state == S_WAIT) ? x_size_m1 : r_xsz;
  assign w_cur_ysz   = (r_state == S_WAIT) ? y_size_m1 : r_ysz;

  assign w_hs        = m_axis_video_tvalid & m_axis_video_tready;
  assign w_eol       = w_hs & m_axis_video_tlast;
  assign w_early     = w_eol & s_axis_video_tlast & (w_cur_x != w_cur_xsz);
  assign w_late      = w_eol & ~s_axis_video_tlast;
  assign w_last_line = (w_cur_y == w_cur_ysz);
  assign w_midsof    = ((r_state == S_PASS) | (r_state == S_DISC)) &
                       s_axis_video_tvalid & s_axis_video_tuser;
  assign w_disc_end  = (r_state == S_DISC) & s_axis_video_tvalid &
                       ~s_axis_video_tuser & s_axis_video_tlast;
  assign w_finish    = (w_eol & ~w_late & w_last_line) | (w_disc_end & r_disc_last);
  assign w_rearm     = capture_continuous | r_pending | capture_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_x           <= '0;
      r_y           <= '0;
      r_xsz         <= '0;
      r_ysz         <= '0;
      r_pending     <= 1'b0;
      r_disc_last   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_err_early   <= 1'b0;
      r_err_late    <= 1'b0;
      r_err_sof     <= 1'b0;
      r_err_abort   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (capture_abort) begin
        r_state   <= S_IDLE;
        r_pending <= 1'b0;
        if (r_state == S_PASS || r_state == S_DISC)
          r_err_abort <= 1'b1;
      end else begin
        if (capture_start && r_state != S_IDLE)
          r_pending <= 1'b1;
        if (r_state == S_IDLE) begin
          if (capture_start) begin
            r_state     <= S_WAIT;
            r_err_early <= 1'b0;
            r_err_late  <= 1'b0;
            r_err_sof   <= 1'b0;
            r_err_abort <= 1'b0;
          end
        end else if (w_midsof) begin
          // The SOF beat stays on the bus and is taken by WAIT_SOF next cycle.
          r_err_sof    <= 1'b1;
          r_frame_done <= 1'b1;
          r_state      <= S_WAIT;
        end else if (w_hs) begin
          if (r_state == S_WAIT) begin
            r_xsz   <= x_size_m1;
            r_ysz   <= y_size_m1;
            r_state <= S_PASS;
          end
          r_x <= w_cur_x + 1'b1;
          r_y <= w_cur_y;
          if (w_eol) begin
            r_x <= '0;
            r_y <= w_cur_y + 1'b1;
            if (w_early)
              r_err_early <= 1'b1;
            if (w_late) begin
              r_err_late  <= 1'b1;
              r_disc_last <= w_last_line;
              r_state     <= S_DISC;
            end
          end
        end else if (w_disc_end) begin
          r_state <= S_PASS;
        end

        if (w_finish) begin
          r_frame_done  <= 1'b1;
          r_frame_count <= r_frame_count + 1'b1;
          r_pending     <= 1'b0;
          r_x           <= '0;
          r_y           <= '0;
          r_state       <= w_rearm ? S_WAIT : S_IDLE;
        end
      end
    end
  end

  assign m_axis_video_tdata = s_axis_video_tdata;
  assign busy               = (r_state != S_IDLE);
  assign frame_start        = (r_state == S_WAIT) & w_hs;
  assign frame_done         = r_frame_done;
  assign frame_count        = r_frame_count;
  assign err_early_eol      = r_err_early;
  assign err_late_eol       = r_err_late;
  assign err_sof_midframe   = r_err_sof;
  assign err_abort          = r_err_abort;

endmodule
